// File: rtl/axi_delay_pkg.sv
// Shared types and constants for the delay-injecting round-robin arbiter.
package axi_delay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axi_delay_rr_pick.sv
// Round-robin winner search: first set request strictly after last_grant, wrapping.
module axi_delay_rr_pick
  import axi_delay_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0] sum;

  // One spare bit keeps last_grant + offset from overflowing before the modulo fold.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!valid && req[sum[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_delay_arbiter.sv
// Round-robin arbiter that holds off each granted transfer for a programmable delay.
// Define AXI_DELAY_ARBITER_LFSR_EN to take the delay from an internal LFSR instead of cfg_delay.
module axi_delay_arbiter
  import axi_delay_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DELAY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         s_valid,
  output logic [NUM_REQ-1:0]         s_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(NUM_REQ)-1:0] m_sel,
  input  logic [DELAY_WIDTH-1:0]     cfg_delay,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [DELAY_WIDTH-1:0] new_delay;
  logic                   req_live;
  logic                   handshake;

  axi_delay_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (s_valid),
    .last_grant(last_grant_q),
    .winner    (pick_idx),
    .valid     (pick_valid)
  );

  assign req_live  = s_valid[grant_q];
  assign handshake = (state_q == ACTIVE) && req_live && m_ready;

`ifdef AXI_DELAY_ARBITER_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (handshake) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign new_delay = lfsr_q[DELAY_WIDTH-1:0];
`else
  assign new_delay = cfg_delay;
`endif

  // The delay is latched at grant time, so later cfg_delay changes cannot disturb it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_valid      = 1'b0;
    s_ready      = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          cnt_d   = new_delay;
          state_d = (new_delay != '0) ? DELAY : ACTIVE;
        end
      end
      DELAY: begin
        if (!req_live) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DELAY_WIDTH'(1);
          if (cnt_q == DELAY_WIDTH'(1)) begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        m_valid          = req_live;
        s_ready[grant_q] = m_ready;
        if (!req_live) begin
          state_d = IDLE;
        end else if (handshake) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      m_valid = 1'b0;
      s_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy  = !rst && (state_q != IDLE);
  assign m_sel = rst ? '0 : grant_q;

endmodule

// File: tb/tb_axi_delay_arbiter.sv
// Scoreboard bench for axi_delay_arbiter: stimulus pushes expected grants, a monitor checks handshakes.
module tb_axi_delay_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s_valid = '0;
  logic [3:0] s_ready;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [1:0] m_sel;
  logic [2:0] cfg_delay = '0;
  logic       busy;

  int total = 0;
  int bad = 0;
  int sel_q[$];
  int dly_q[$];

  axi_delay_arbiter #(
    .NUM_REQ    (4),
    .DELAY_WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_sel    (m_sel),
    .cfg_delay(cfg_delay),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [2:0] dly, input logic rdy);
    tick();
    s_valid   = req;
    cfg_delay = dly;
    m_ready   = rdy;
  endtask

  task automatic expectGrant(input int sel, input int dly);
    sel_q.push_back(sel);
    dly_q.push_back(dly);
  endtask

  task automatic doReset();
    tick();
    rst       = 1'b1;
    s_valid   = '0;
    m_ready   = 1'b0;
    cfg_delay = '0;
    tick();
    @(negedge clk);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_m_sel", m_sel, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic waitHandshake(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) seen = 1'b1;
    end
    checkOutput(name, seen, 1);
    tick();
    s_valid = '0;
  endtask

  // Monitor: counts DELAY cycles (busy without m_valid) and checks each handshake against the queue.
  initial begin
    int          dcnt = 0;
    logic [15:0] model = 16'hACE1;
    int          esel;
    int          edly;
    forever begin
      @(negedge clk);
      if (rst) begin
        dcnt  = 0;
        model = 16'hACE1;
      end else if (!busy) begin
        dcnt = 0;
      end else if (!m_valid) begin
        dcnt++;
      end else if (m_ready) begin
        if (sel_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_hs: got handshake sel=%0d expected none", m_sel);
        end else begin
          esel = sel_q.pop_front();
          edly = dly_q.pop_front();
`ifdef AXI_DELAY_ARBITER_LFSR_EN
          edly = int'(model[2:0]);
`endif
          checkOutput("hs_sel", m_sel, esel);
          checkOutput("hs_delay", dcnt, edly);
          checkOutput("hs_s_ready", s_ready, 1 << esel);
        end
        model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
        dcnt  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs_seen;

    // Single requester, delay 3: m_valid after 3 DELAY cycles, then idle.
    doReset();
    expectGrant(0, 3);
    applyStimulus(4'b0001, 3'd3, 1'b1);
    waitHandshake("t1_hs");
    @(negedge clk);
    checkOutput("t1_busy_drop", busy, 0);
    checkOutput("t1_s_ready_pulse", s_ready, 0);
    checkOutput("t1_m_valid_low", m_valid, 0);

    // All requesting, zero delay: rotation 0,1,2,3,0 with an idle cycle between.
    doReset();
    expectGrant(0, 0);
    expectGrant(1, 0);
    expectGrant(2, 0);
    expectGrant(3, 0);
    expectGrant(0, 0);
    applyStimulus(4'b1111, 3'd0, 1'b1);
    hs_seen = 0;
    for (int i = 0; i < 200 && hs_seen < 5; i++) begin
      @(negedge clk);
`ifndef AXI_DELAY_ARBITER_LFSR_EN
      checkOutput("t2_busy_pattern", busy, i % 2);
`endif
      if (m_valid && m_ready) hs_seen++;
    end
    checkOutput("t2_hs_count", hs_seen, 5);
    tick();
    s_valid = '0;

    // Abandon grant 2 during DELAY; last_grant stays 3 so 4'b0110 grants 1.
    doReset();
    applyStimulus(4'b0100, 3'd3, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t3_m_sel", m_sel, 2);
    checkOutput("t3_busy", busy, 1);
    tick();
    s_valid = 4'b0000;
    tick();
    s_valid = 4'b0110;
    expectGrant(1, 3);
    @(negedge clk);
    checkOutput("t3_abandon_idle", busy, 0);
    waitHandshake("t3_hs");

    // Reset while ACTIVE and stalled: outputs clear, then requester 0 wins over 3.
    doReset();
    applyStimulus(4'b1000, 3'd0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("t4_stall_m_valid", m_valid, 1);
    checkOutput("t4_stall_m_sel", m_sel, 3);
    checkOutput("t4_stall_s_ready", s_ready, 0);
    tick();
    rst     = 1'b1;
    s_valid = 4'b1001;
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    expectGrant(0, 0);
    @(negedge clk);
    checkOutput("t4_post_m_valid", m_valid, 0);
    checkOutput("t4_post_s_ready", s_ready, 0);
    checkOutput("t4_post_busy", busy, 0);
    checkOutput("t4_post_m_sel", m_sel, 0);
    waitHandshake("t4_hs");

    // cfg_delay changed 5 -> 1 after the grant: still 5 DELAY cycles.
    expectGrant(1, 5);
    applyStimulus(4'b0010, 3'd5, 1'b1);
    tick();
    cfg_delay = 3'd1;
    waitHandshake("t5_hs");

    tick();
    tick();
    checkOutput("queue_empty", sel_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
